// File: rtl/bsg_capture_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_capture_reg_rr_arbiter
// Purpose  : One shared width_p-bit capture register time-shared by els_p
//            valid/yumi requesters under round-robin arbitration. The winning
//            requester's data is latched with its index and held with v_o
//            until the consumer yumis. A new winner may be loaded in the same
//            cycle the consumer takes the current contents.
// Ports    : clk_i      - clock, all state updates on posedge
//            reset_n_i  - asynchronous active-low reset
//            v_i        - per-requester valid
//            data_i     - requester k data at [k*width_p +: width_p]
//            yumi_o     - one-hot grant, data_i[k] consumed this cycle
//            v_o        - shared register holds valid data
//            data_o     - shared register contents
//            tag_o      - index of the requester whose data is in data_o
//            yumi_i     - consumer takes data_o this cycle
// Revision : 1.0 - initial release
// ============================================================================
module bsg_capture_reg_rr_arbiter #(
   parameter int width_p           = 16,
   parameter int els_p             = 4,
   // When set, a consumer yumi while the register is empty is flagged in
   // simulation. The hardware ignores such a yumi either way.
   parameter bit strict_consumer_p = 1'b1,
   localparam int lg_els_lp        = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic [els_p-1:0]           v_i,
   input  logic [els_p*width_p-1:0]   data_i,
   output logic [els_p-1:0]           yumi_o,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   output logic [lg_els_lp-1:0]       tag_o,
   input  logic                       yumi_i
);

   // ------------------------------------------------------------------------
   // State encoding: the state bit is v_o itself.
   // ------------------------------------------------------------------------
   localparam logic [0:0] state_empty_lp = 1'b0;
   localparam logic [0:0] state_full_lp  = 1'b1;

   // Scan arithmetic carries one extra bit so ptr + offset never overflows
   // before the wrap correction.
   localparam int               scan_w_lp = lg_els_lp + 1;
   localparam logic [scan_w_lp-1:0] els_lp = scan_w_lp'(els_p);

   logic [0:0]            state_q, state_d;
   logic [width_p-1:0]    data_q,  data_d;
   logic [lg_els_lp-1:0]  tag_q,   tag_d;
   logic [lg_els_lp-1:0]  ptr_q,   ptr_d;

   logic                  can_load;
   logic                  grant_found;
   logic                  grant_v;
   logic [lg_els_lp-1:0]  grant_idx;
   logic [scan_w_lp-1:0]  scan_idx;

   // ------------------------------------------------------------------------
   // Unpack the flat requester data bus.
   // ------------------------------------------------------------------------
   logic [width_p-1:0] req_data [els_p];

   for (genvar k = 0; k < els_p; k++) begin : g_unpack
      assign req_data[k] = data_i[k*width_p +: width_p];
   end

   // ------------------------------------------------------------------------
   // Round-robin search: start one past the last winner and take the first
   // asserted valid, wrapping from els_p-1 back to 0. The last winner is
   // visited last, which bounds any waiting requester to els_p-1 grants.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int off = 1; off <= els_p; off++) begin
         scan_idx = {1'b0, ptr_q} + scan_w_lp'(off);
         if (scan_idx >= els_lp) begin
            scan_idx = scan_idx - els_lp;
         end
         if (!grant_found && v_i[scan_idx[lg_els_lp-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[lg_els_lp-1:0];
         end
      end
   end

   // The register can accept new data when empty or when it is being drained
   // this very cycle; the latter gives back-to-back transfers with no bubble.
   // No grant is issued while reset is held.
   assign can_load = (state_q == state_empty_lp) | yumi_i;
   assign grant_v  = can_load & grant_found & reset_n_i;

   always_comb begin
      yumi_o = '0;
      if (grant_v) begin
         yumi_o[grant_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. A grant always wins over a drain: if the consumer
   // takes the contents and a requester is granted in the same cycle, the
   // register is simply overwritten and stays full. A yumi while empty has
   // no effect. The pointer only moves on an actual grant.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      tag_d   = tag_q;
      ptr_d   = ptr_q;
      if (grant_v) begin
         state_d = state_full_lp;
         data_d  = req_data[grant_idx];
         tag_d   = grant_idx;
         ptr_d   = grant_idx;
      end else if ((state_q == state_full_lp) && yumi_i) begin
         state_d = state_empty_lp;
      end
   end

   // Reset pointer at els_p-1 so requester 0 has top priority afterwards.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= state_empty_lp;
         data_q  <= '0;
         tag_q   <= '0;
         ptr_q   <= lg_els_lp'(els_p - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         ptr_q   <= ptr_d;
      end
   end

   assign v_o    = (state_q == state_full_lp);
   assign data_o = data_q;
   assign tag_o  = tag_q;

`ifndef SYNTHESIS
   // ------------------------------------------------------------------------
   // Protocol checks. chk_en_q drops asynchronously with reset so nothing is
   // checked on edges taken while reset is held.
   // ------------------------------------------------------------------------
   logic             chk_en_q;
   logic [els_p-1:0] v_prev_q;
   logic [els_p-1:0] yumi_prev_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         chk_en_q    <= 1'b0;
         v_prev_q    <= '0;
         yumi_prev_q <= '0;
      end else begin
         chk_en_q    <= 1'b1;
         v_prev_q    <= v_i;
         yumi_prev_q <= yumi_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (chk_en_q) begin
         if (strict_consumer_p) begin
            assert (!(yumi_i && (state_q == state_empty_lp)))
               else $error("consumer yumi while register empty");
         end
         assert ($countones(yumi_o) <= 1)
            else $error("grant vector not one-hot: %b", yumi_o);
         for (int k = 0; k < els_p; k++) begin
            assert (!(v_prev_q[k] && !v_i[k] && !yumi_prev_q[k]))
               else $error("requester %0d dropped valid without a grant", k);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_capture_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_capture_reg_rr_arbiter
// Purpose  : Self-checking bench for bsg_capture_reg_rr_arbiter. Requesters
//            are modelled as FIFOs of pending words; a reference model tracks
//            the register contents and the last-grant index and predicts the
//            grant from the round-robin rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_capture_reg_rr_arbiter;
   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   v_i;
   logic [N*W-1:0] data_i;
   logic [N-1:0]   yumi_o;
   logic           v_o;
   logic [W-1:0]   data_o;
   logic [1:0]     tag_o;
   logic           yumi_i;

   int checks = 0;
   int errors = 0;

   // Pending words per requester; the head is what the requester presents.
   logic [W-1:0] q [N][$];

   // Reference model state.
   bit           m_v;
   logic [W-1:0] m_data;
   int           m_tag;
   int           m_ptr;

   bsg_capture_reg_rr_arbiter #(
      .width_p          (W),
      .els_p            (N),
      .strict_consumer_p(1'b0)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .v_i      (v_i),
      .data_i   (data_i),
      .yumi_o   (yumi_o),
      .v_o      (v_o),
      .data_o   (data_o),
      .tag_o    (tag_o),
      .yumi_i   (yumi_i)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Model helpers (no comparisons here).
   // ------------------------------------------------------------------------
   function automatic int exp_winner();
      if (!reset_n) return -1;
      if (m_v && !yumi_i) return -1;
      for (int off = 1; off <= N; off++) begin
         int idx;
         idx = (m_ptr + off) % N;
         if (q[idx].size() > 0) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] r;
      r = '0;
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         v_i[k]           = (q[k].size() != 0);
         data_i[k*W +: W] = (q[k].size() != 0) ? q[k][0] : '0;
      end
   endtask

   task automatic model_reset();
      m_v    = 1'b0;
      m_data = '0;
      m_tag  = 0;
      m_ptr  = N - 1;
   endtask

   // Take one rising edge, update the model with the predicted winner w,
   // then re-present requester heads.
   task automatic advance(input int w);
      @(posedge clk);
      if (w >= 0) begin
         m_data = q[w].pop_front();
         m_tag  = w;
         m_v    = 1'b1;
         m_ptr  = w;
      end else if (yumi_i && m_v) begin
         m_v = 1'b0;
      end
      #1;
      drive_inputs();
   endtask

   task automatic reset_dut(input bit clear);
      reset_n = 1'b0;
      yumi_i  = 1'b0;
      if (clear) begin
         for (int k = 0; k < N; k++) q[k].delete();
      end
      drive_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Reset: all requesters valid while reset held; requester 0 first after.
   // ------------------------------------------------------------------------
   task automatic test_reset();
      int w;
      reset_n = 1'b0;
      yumi_i  = 1'b0;
      for (int k = 0; k < N; k++) begin
         q[k].delete();
         q[k].push_back(16'h5500 + 16'(k));
      end
      drive_inputs();
      model_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (v_o !== 1'b0 || data_o !== 16'h0 || tag_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs c=%0d v_o=%b data_o=%h tag_o=%0d required 0/0000/0", c, v_o, data_o, tag_o);
         end
         checks++;
         if (yumi_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_yumi c=%0d yumi_o=%b required 0000", c, yumi_o);
         end
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (yumi_o !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant yumi_o=%b required 0001", yumi_o);
      end
      w = exp_winner();
      advance(w);
      @(negedge clk);
      checks++;
      if (v_o !== 1'b1 || tag_o !== 2'd0 || data_o !== 16'h5500) begin
         errors++;
         $display("FAIL reset_first_load v_o=%b tag_o=%0d data_o=%h required 1/0/5500", v_o, tag_o, data_o);
      end
   endtask

   // ------------------------------------------------------------------------
   // Rotation: all valid, consumer always ready.
   // ------------------------------------------------------------------------
   task automatic test_rotation();
      int w;
      reset_dut(1'b1);
      for (int k = 0; k < N; k++)
         for (int j = 0; j < 3; j++) q[k].push_back(16'hA0A0 + 16'(k));
      drive_inputs();
      for (int c = 0; c < 8; c++) begin
         yumi_i = m_v;
         @(negedge clk);
         if (c > 0) begin
            checks++;
            if (v_o !== 1'b1 || tag_o !== 2'((c-1) % N) || data_o !== 16'hA0A0 + 16'((c-1) % N)) begin
               errors++;
               $display("FAIL rotation_seq c=%0d v_o=%b tag_o=%0d data_o=%h required 1/%0d/%h",
                        c, v_o, tag_o, data_o, (c-1) % N, 16'hA0A0 + 16'((c-1) % N));
            end
         end
         w = exp_winner();
         checks++;
         if (yumi_o !== onehot(w)) begin
            errors++;
            $display("FAIL rotation_yumi c=%0d yumi_o=%b required %b", c, yumi_o, onehot(w));
         end
         advance(w);
      end
   endtask

   // ------------------------------------------------------------------------
   // Backpressure: consumer stalls, then drains with a same-cycle reload.
   // ------------------------------------------------------------------------
   task automatic test_backpressure();
      int w;
      reset_dut(1'b1);
      q[0].push_back(16'h1111);
      q[2].push_back(16'h2222);
      drive_inputs();
      for (int c = 0; c < 5; c++) begin
         yumi_i = (c == 4);
         @(negedge clk);
         w = exp_winner();
         checks++;
         if (yumi_o !== onehot(w) || (c == 0 && yumi_o !== 4'b0001) || (c == 4 && yumi_o !== 4'b0100)) begin
            errors++;
            $display("FAIL bp_yumi c=%0d yumi_o=%b required %b", c, yumi_o, onehot(w));
         end
         if (c > 0) begin
            checks++;
            if (v_o !== 1'b1 || data_o !== 16'h1111 || tag_o !== 2'd0) begin
               errors++;
               $display("FAIL bp_hold c=%0d v_o=%b data_o=%h tag_o=%0d required 1/1111/0", c, v_o, data_o, tag_o);
            end
         end
         advance(w);
      end
      yumi_i = 1'b0;
      @(negedge clk);
      checks++;
      if (v_o !== 1'b1 || tag_o !== 2'd2 || data_o !== 16'h2222) begin
         errors++;
         $display("FAIL bp_reload v_o=%b tag_o=%0d data_o=%h required 1/2/2222", v_o, tag_o, data_o);
      end
   endtask

   // ------------------------------------------------------------------------
   // Skip/wrap: last grant req2, then 0011 -> req0, then 1010 -> req1, req3.
   // ------------------------------------------------------------------------
   task automatic test_skip_wrap();
      logic [N-1:0] exp_seq [4];
      int w;
      exp_seq[0] = 4'b0100;
      exp_seq[1] = 4'b0001;
      exp_seq[2] = 4'b0010;
      exp_seq[3] = 4'b1000;
      reset_dut(1'b1);
      q[2].push_back(16'h4442);
      drive_inputs();
      for (int c = 0; c < 4; c++) begin
         yumi_i = m_v;
         @(negedge clk);
         w = exp_winner();
         checks++;
         if (yumi_o !== exp_seq[c] || yumi_o !== onehot(w)) begin
            errors++;
            $display("FAIL skip_wrap_yumi c=%0d yumi_o=%b required %b", c, yumi_o, exp_seq[c]);
         end
         advance(w);
         if (c == 0) begin
            q[0].push_back(16'h4440);
            q[1].push_back(16'h4441);
         end
         if (c == 1) q[3].push_back(16'h4443);
         drive_inputs();
      end
      yumi_i = 1'b0;
      @(negedge clk);
      checks++;
      if (v_o !== 1'b1 || tag_o !== 2'd3 || data_o !== 16'h4443) begin
         errors++;
         $display("FAIL skip_wrap_last v_o=%b tag_o=%0d data_o=%h required 1/3/4443", v_o, tag_o, data_o);
      end
   endtask

   // ------------------------------------------------------------------------
   // Drain: register empties, keeps data, ignores yumi while empty.
   // ------------------------------------------------------------------------
   task automatic test_drain();
      int w;
      reset_dut(1'b1);
      q[1].push_back(16'hBEEF);
      drive_inputs();
      for (int c = 0; c < 5; c++) begin
         yumi_i = (c >= 1);
         @(negedge clk);
         w = exp_winner();
         checks++;
         if (yumi_o !== onehot(w)) begin
            errors++;
            $display("FAIL drain_yumi c=%0d yumi_o=%b required %b", c, yumi_o, onehot(w));
         end
         checks++;
         if (v_o !== m_v || data_o !== m_data || tag_o !== 2'(m_tag)) begin
            errors++;
            $display("FAIL drain_regs c=%0d v_o=%b data_o=%h tag_o=%0d required %b/%h/%0d",
                     c, v_o, data_o, tag_o, m_v, m_data, m_tag);
         end
         advance(w);
      end
      @(negedge clk);
      checks++;
      if (v_o !== 1'b0 || data_o !== 16'hBEEF || tag_o !== 2'd1) begin
         errors++;
         $display("FAIL drain_empty v_o=%b data_o=%h tag_o=%0d required 0/beef/1", v_o, data_o, tag_o);
      end
      yumi_i = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Async reset while full; pending requester 1 wins after release.
   // ------------------------------------------------------------------------
   task automatic test_async_reset();
      int w;
      reset_dut(1'b1);
      q[0].push_back(16'h6660);
      drive_inputs();
      yumi_i = 1'b0;
      @(negedge clk);
      w = exp_winner();
      advance(w);
      q[1].push_back(16'h6661);
      drive_inputs();
      #2;
      checks++;
      if (v_o !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre v_o=%b required 1", v_o);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (v_o !== 1'b0 || data_o !== 16'h0 || yumi_o !== 4'b0000) begin
         errors++;
         $display("FAIL areset_drop v_o=%b data_o=%h yumi_o=%b required 0/0000/0000", v_o, data_o, yumi_o);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      w = exp_winner();
      checks++;
      if (yumi_o !== 4'b0010 || yumi_o !== onehot(w)) begin
         errors++;
         $display("FAIL areset_regrant yumi_o=%b required 0010", yumi_o);
      end
      advance(w);
      @(negedge clk);
      checks++;
      if (v_o !== 1'b1 || tag_o !== 2'd1 || data_o !== 16'h6661) begin
         errors++;
         $display("FAIL areset_load v_o=%b tag_o=%0d data_o=%h required 1/1/6661", v_o, tag_o, data_o);
      end
   endtask

   // ------------------------------------------------------------------------
   // Random traffic against the reference model.
   // ------------------------------------------------------------------------
   task automatic test_random();
      int w;
      reset_dut(1'b1);
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0 && q[k].size() < 4)
               q[k].push_back(16'($urandom));
         end
         drive_inputs();
         yumi_i = m_v ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         w = exp_winner();
         checks++;
         if (yumi_o !== onehot(w)) begin
            errors++;
            $display("FAIL random_yumi c=%0d yumi_o=%b required %b", c, yumi_o, onehot(w));
         end
         checks++;
         if (v_o !== m_v || data_o !== m_data || tag_o !== 2'(m_tag)) begin
            errors++;
            $display("FAIL random_regs c=%0d v_o=%b data_o=%h tag_o=%0d required %b/%h/%0d",
                     c, v_o, data_o, tag_o, m_v, m_data, m_tag);
         end
         advance(w);
      end
      yumi_i = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      yumi_i  = 1'b0;
      v_i     = '0;
      data_i  = '0;
      test_reset();
      test_rotation();
      test_backpressure();
      test_skip_wrap();
      test_drain();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
